control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 31 +++
 rtl/control_sequencer.sv | 137 +++++++++++++
 tb/tb_control_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Fetch-unit <-> control-sequencer bus: instruction/flag inputs and the
// one-cycle control pulses, immediates and status back to the fetch unit.
interface control_sequencer_if;
  logic [3:0] pc;
  logic [7:0] instr_data;
  logic       zero_flag;
  logic       stall;
  logic       jump, beq_set, bne_set, call, ret, write_enable;
  logic [3:0] imm_address, imm_address_jump, imm_address_branch;
  logic       alu_en;
  logic [1:0] alu_op;
  logic       mem_read, mem_write;
  logic       halted, stack_fault, illegal_op;
  logic [3:0] dbg_pc;

  modport master (
    output pc, instr_data, zero_flag, stall,
    input  jump, beq_set, bne_set, call, ret, write_enable,
    input  imm_address, imm_address_jump, imm_address_branch,
    input  alu_en, alu_op, mem_read, mem_write,
    input  halted, stack_fault, illegal_op, dbg_pc
  );

  modport slave (
    input  pc, instr_data, zero_flag, stall,
    output jump, beq_set, bne_set, call, ret, write_enable,
    output imm_address, imm_address_jump, imm_address_branch,
    output alu_en, alu_op, mem_read, mem_write,
    output halted, stack_fault, illegal_op, dbg_pc
  );
endinterface

// File: rtl/control_sequencer.sv
// Three-phase FETCH/DECODE/EXECUTE control sequencer with call-depth
// tracking, sticky fault flags and a terminal HALT state.
module control_sequencer (
  input  logic              clk,
  input  logic              reset,
  control_sequencer_if.slave bus
);
  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_LOAD = 4'h3,
                         OP_STORE = 4'h4, OP_JMP = 4'h5, OP_BEQ = 4'h6, OP_BNE = 4'h7,
                         OP_CALL = 4'h8, OP_RET = 4'h9, OP_HLT = 4'hF;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_ir;
  logic       r_take;
  logic [3:0] r_depth;
  logic [3:0] r_dbg_pc;
  logic       r_stack_fault, r_illegal_op;

  logic [3:0] w_opcode;
  logic       w_latch_ir, w_latch_take, w_take_nxt;
  logic       w_depth_inc, w_depth_dec, w_set_fault, w_set_illegal;
  logic       w_jump, w_beq, w_bne, w_call, w_ret, w_we;
  logic       w_alu_en, w_mem_read, w_mem_write;
  logic [1:0] w_alu_op;

  assign w_opcode   = r_ir[7:4];
  assign w_take_nxt = (w_opcode == OP_BEQ) ? bus.zero_flag :
                      (w_opcode == OP_BNE) ? ~bus.zero_flag : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= FETCH;
      r_ir          <= 8'h00;
      r_take        <= 1'b0;
      r_depth       <= 4'd0;
      r_dbg_pc      <= 4'd0;
      r_stack_fault <= 1'b0;
      r_illegal_op  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_ir) begin
        r_ir     <= bus.instr_data;
        r_dbg_pc <= bus.pc;
      end
      if (w_latch_take)  r_take        <= w_take_nxt;
      if (w_depth_inc)   r_depth       <= r_depth + 4'd1;
      if (w_depth_dec)   r_depth       <= r_depth - 4'd1;
      if (w_set_fault)   r_stack_fault <= 1'b1;
      if (w_set_illegal) r_illegal_op  <= 1'b1;
    end
  end

  // Everything below is inert while reset is high or stall freezes the FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_latch_ir    = 1'b0;
    w_latch_take  = 1'b0;
    w_depth_inc   = 1'b0;
    w_depth_dec   = 1'b0;
    w_set_fault   = 1'b0;
    w_set_illegal = 1'b0;
    w_jump        = 1'b0;
    w_beq         = 1'b0;
    w_bne         = 1'b0;
    w_call        = 1'b0;
    w_ret         = 1'b0;
    w_we          = 1'b0;
    w_alu_en      = 1'b0;
    w_alu_op      = 2'b00;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    if (!reset) begin
      unique case (r_state)
        FETCH: if (!bus.stall) begin
          w_latch_ir  = 1'b1;
          w_state_nxt = DECODE;
        end
        DECODE: if (!bus.stall) begin
          w_latch_take = 1'b1;
          w_state_nxt  = EXECUTE;
        end
        EXECUTE: if (!bus.stall) begin
          w_state_nxt = FETCH;
          case (w_opcode)
            OP_NOP:   w_we = 1'b1;
            OP_ADD:   begin w_alu_en = 1'b1; w_we = 1'b1; end
            OP_SUB:   begin w_alu_en = 1'b1; w_alu_op = 2'b01; w_we = 1'b1; end
            OP_LOAD:  begin w_mem_read = 1'b1; w_we = 1'b1; end
            OP_STORE: begin w_mem_write = 1'b1; w_we = 1'b1; end
            OP_JMP:   w_jump = 1'b1;
            OP_BEQ:   begin w_beq = r_take; w_we = ~r_take; end
            OP_BNE:   begin w_bne = r_take; w_we = ~r_take; end
            OP_CALL:
              if (r_depth == 4'd15) begin
                w_set_fault = 1'b1;
                w_state_nxt = HALT;
              end else begin
                w_call      = 1'b1;
                w_depth_inc = 1'b1;
              end
            OP_RET:
              if (r_depth == 4'd0) begin
                w_set_fault = 1'b1;
                w_state_nxt = HALT;
              end else begin
                w_ret       = 1'b1;
                w_depth_dec = 1'b1;
              end
            OP_HLT:   w_state_nxt = HALT;
            default:  begin w_we = 1'b1; w_set_illegal = 1'b1; end
          endcase
        end
        HALT: w_state_nxt = HALT;
      endcase
    end
  end

  assign bus.jump               = w_jump;
  assign bus.beq_set            = w_beq;
  assign bus.bne_set            = w_bne;
  assign bus.call               = w_call;
  assign bus.ret                = w_ret;
  assign bus.write_enable       = w_we;
  assign bus.alu_en             = w_alu_en;
  assign bus.alu_op             = w_alu_op;
  assign bus.mem_read           = w_mem_read;
  assign bus.mem_write          = w_mem_write;
  assign bus.imm_address        = r_ir[3:0] & {4{~reset}};
  assign bus.imm_address_jump   = r_ir[3:0] & {4{~reset}};
  assign bus.imm_address_branch = r_ir[3:0] & {4{~reset}};
  assign bus.dbg_pc             = r_dbg_pc & {4{~reset}};
  assign bus.halted             = (r_state == HALT) && !reset;
  assign bus.stack_fault        = r_stack_fault && !reset;
  assign bus.illegal_op         = r_illegal_op && !reset;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one task per scenario, inline checks.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  control_sequencer_if u_if ();
  control_sequencer dut (.clk(clk), .reset(reset), .bus(u_if));

  always #5 clk = ~clk;

  // Pulse vector order: jump beq bne call ret we alu_en alu_op[1:0] mem_read mem_write
  localparam logic [10:0] P_NONE = 11'h000, P_WE = 11'h020, P_ADD = 11'h030,
                          P_SUB = 11'h034, P_LOAD = 11'h022, P_STORE = 11'h021,
                          P_JMP = 11'h400, P_BEQ = 11'h200, P_BNE = 11'h100,
                          P_CALL = 11'h080, P_RET = 11'h040;

  function automatic logic [10:0] pulses();
    return {u_if.jump, u_if.beq_set, u_if.bne_set, u_if.call, u_if.ret,
            u_if.write_enable, u_if.alu_en, u_if.alu_op, u_if.mem_read, u_if.mem_write};
  endfunction

  task automatic step(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk);     endtask

  // Leaves the bench 1 time unit after the edge that starts the first FETCH cycle.
  task automatic do_reset();
    reset = 1'b1; u_if.stall = 1'b0; u_if.instr_data = 8'h00;
    u_if.zero_flag = 1'b0; u_if.pc = 4'h0;
    step(); step();
    reset = 1'b0;
  endtask

  // Runs one instruction through FETCH/DECODE/EXECUTE, ends at the next FETCH.
  task automatic run_instr(input logic [7:0] ins, input logic [3:0] p, input logic zf,
                           output logic [10:0] obs, output logic [3:0] imm_d,
                           output logic [7:0] imm_e, output logic [3:0] dbg);
    u_if.instr_data = ins; u_if.pc = p; u_if.zero_flag = zf;
    smp(); step();
    u_if.instr_data = 8'hFF; u_if.pc = 4'hF;
    smp(); imm_d = u_if.imm_address; dbg = u_if.dbg_pc; step();
    smp(); obs = pulses(); imm_e = {u_if.imm_address_jump, u_if.imm_address_branch}; step();
  endtask

  task automatic test_reset();
    reset = 1'b1; u_if.stall = 1'b1; u_if.instr_data = 8'h5A;
    u_if.zero_flag = 1'b1; u_if.pc = 4'h7;
    step(); step(); smp();
    n_tests++; if (pulses() !== P_NONE) begin n_fail++; $display("FAIL reset_pulses: got %h exp %h", pulses(), P_NONE); end
    n_tests++; if ({u_if.halted, u_if.stack_fault, u_if.illegal_op} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b exp 000", {u_if.halted, u_if.stack_fault, u_if.illegal_op}); end
    n_tests++; if ({u_if.dbg_pc, u_if.imm_address} !== 8'h00) begin n_fail++; $display("FAIL reset_regs: got %h exp 00", {u_if.dbg_pc, u_if.imm_address}); end
  endtask

  task automatic test_nop_stream();
    logic [10:0] exp;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      smp();
      exp = (c % 3 == 0) ? P_WE : P_NONE;
      n_tests++; if (pulses() !== exp) begin n_fail++; $display("FAIL nop_cycle%0d: got %h exp %h", c, pulses(), exp); end
      step();
    end
  endtask

  task automatic test_alu_mem();
    logic [10:0] obs; logic [3:0] imm_d, dbg; logic [7:0] imm_e;
    do_reset();
    run_instr(8'h12, 4'h3, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_ADD) begin n_fail++; $display("FAIL add_pulse: got %h exp %h", obs, P_ADD); end
    n_tests++; if ({imm_d, dbg} !== 8'h23) begin n_fail++; $display("FAIL add_imm_dbg: got %h exp 23", {imm_d, dbg}); end
    run_instr(8'h25, 4'h4, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_SUB) begin n_fail++; $display("FAIL sub_pulse: got %h exp %h", obs, P_SUB); end
    n_tests++; if ({imm_d, dbg} !== 8'h54) begin n_fail++; $display("FAIL sub_imm_dbg: got %h exp 54", {imm_d, dbg}); end
    run_instr(8'h31, 4'h5, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_LOAD) begin n_fail++; $display("FAIL load_pulse: got %h exp %h", obs, P_LOAD); end
    run_instr(8'h4C, 4'h6, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_STORE) begin n_fail++; $display("FAIL store_pulse: got %h exp %h", obs, P_STORE); end
  endtask

  task automatic test_branch();
    logic [10:0] obs; logic [3:0] imm_d, dbg; logic [7:0] imm_e;
    do_reset();
    run_instr(8'h6A, 4'h1, 1'b1, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_BEQ) begin n_fail++; $display("FAIL beq_taken: got %h exp %h", obs, P_BEQ); end
    n_tests++; if (imm_e[3:0] !== 4'hA) begin n_fail++; $display("FAIL beq_imm_branch: got %h exp a", imm_e[3:0]); end
    run_instr(8'h6A, 4'h2, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_WE) begin n_fail++; $display("FAIL beq_not_taken: got %h exp %h", obs, P_WE); end
    run_instr(8'h73, 4'h3, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_BNE) begin n_fail++; $display("FAIL bne_taken: got %h exp %h", obs, P_BNE); end
    run_instr(8'h73, 4'h4, 1'b1, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_WE) begin n_fail++; $display("FAIL bne_not_taken: got %h exp %h", obs, P_WE); end
    run_instr(8'h57, 4'h5, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_JMP) begin n_fail++; $display("FAIL jmp_pulse: got %h exp %h", obs, P_JMP); end
    n_tests++; if (imm_e !== 8'h77) begin n_fail++; $display("FAIL jmp_imm: got %h exp 77", imm_e); end
  endtask

  task automatic test_illegal();
    logic [10:0] obs; logic [3:0] imm_d, dbg; logic [7:0] imm_e;
    do_reset();
    run_instr(8'hB0, 4'h0, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_WE) begin n_fail++; $display("FAIL illegal_pulse: got %h exp %h", obs, P_WE); end
    run_instr(8'h00, 4'h1, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if ({u_if.illegal_op, u_if.halted} !== 2'b10) begin n_fail++; $display("FAIL illegal_sticky: got %b exp 10", {u_if.illegal_op, u_if.halted}); end
  endtask

  task automatic test_stall();
    do_reset();
    u_if.instr_data = 8'h12;
    smp(); step(); smp(); step();
    u_if.stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      smp();
      n_tests++; if (pulses() !== P_NONE) begin n_fail++; $display("FAIL stall_hold%0d: got %h exp %h", c, pulses(), P_NONE); end
      step();
    end
    u_if.stall = 1'b0; u_if.instr_data = 8'h00;
    smp();
    n_tests++; if (pulses() !== P_ADD) begin n_fail++; $display("FAIL stall_release: got %h exp %h", pulses(), P_ADD); end
    step(); smp();
    n_tests++; if (pulses() !== P_NONE) begin n_fail++; $display("FAIL stall_once: got %h exp %h", pulses(), P_NONE); end
    step(); step(); smp();
    n_tests++; if (pulses() !== P_WE) begin n_fail++; $display("FAIL stall_resume: got %h exp %h", pulses(), P_WE); end
    step();
  endtask

  task automatic test_call_depth();
    logic [10:0] obs; logic [3:0] imm_d, dbg; logic [7:0] imm_e;
    int ncall = 0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      run_instr(8'h83, 4'(i), 1'b0, obs, imm_d, imm_e, dbg);
      if (obs === P_CALL) ncall++;
    end
    n_tests++; if (ncall !== 15) begin n_fail++; $display("FAIL call_count: got %0d exp 15", ncall); end
    run_instr(8'h83, 4'hF, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_NONE) begin n_fail++; $display("FAIL call_overflow_pulse: got %h exp %h", obs, P_NONE); end
    smp();
    n_tests++; if ({u_if.halted, u_if.stack_fault} !== 2'b11) begin n_fail++; $display("FAIL call_overflow_flags: got %b exp 11", {u_if.halted, u_if.stack_fault}); end
    step();
    u_if.instr_data = 8'h00;
    for (int c = 0; c < 6; c++) begin
      u_if.stall = c[0];
      smp();
      n_tests++; if ({pulses(), u_if.halted} !== {P_NONE, 1'b1}) begin n_fail++; $display("FAIL halt_hold%0d: got %h exp %h", c, {pulses(), u_if.halted}, {P_NONE, 1'b1}); end
      step();
    end
    u_if.stall = 1'b0;
  endtask

  task automatic test_call_ret();
    logic [10:0] obs; logic [3:0] imm_d, dbg; logic [7:0] imm_e;
    do_reset();
    run_instr(8'h83, 4'h0, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_CALL) begin n_fail++; $display("FAIL cr_call: got %h exp %h", obs, P_CALL); end
    run_instr(8'h90, 4'h1, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_RET) begin n_fail++; $display("FAIL cr_ret: got %h exp %h", obs, P_RET); end
    run_instr(8'h90, 4'h2, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if ({obs, u_if.halted} !== {P_NONE, 1'b1}) begin n_fail++; $display("FAIL cr_underflow: got %h exp %h", {obs, u_if.halted}, {P_NONE, 1'b1}); end
  endtask

  task automatic test_ret_fault();
    logic [10:0] obs; logic [3:0] imm_d, dbg; logic [7:0] imm_e;
    do_reset();
    run_instr(8'h90, 4'h0, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_NONE) begin n_fail++; $display("FAIL ret0_pulse: got %h exp %h", obs, P_NONE); end
    u_if.instr_data = 8'h00;
    for (int c = 0; c < 4; c++) begin
      smp();
      n_tests++; if ({pulses(), u_if.halted, u_if.stack_fault} !== {P_NONE, 2'b11}) begin n_fail++; $display("FAIL ret0_halt%0d: got %h exp %h", c, {pulses(), u_if.halted, u_if.stack_fault}, {P_NONE, 2'b11}); end
      step();
    end
    reset = 1'b1;
    smp();
    n_tests++; if ({u_if.halted, u_if.stack_fault} !== 2'b00) begin n_fail++; $display("FAIL ret0_during_reset: got %b exp 00", {u_if.halted, u_if.stack_fault}); end
    step();
  endtask

  task automatic test_hlt();
    logic [10:0] obs; logic [3:0] imm_d, dbg; logic [7:0] imm_e;
    do_reset();
    run_instr(8'hF0, 4'h0, 1'b0, obs, imm_d, imm_e, dbg);
    smp();
    n_tests++; if ({obs, u_if.halted, u_if.stack_fault} !== {P_NONE, 2'b10}) begin n_fail++; $display("FAIL hlt: got %h exp %h", {obs, u_if.halted, u_if.stack_fault}, {P_NONE, 2'b10}); end
    step();
  endtask

  task automatic test_reset_mid_exec();
    logic [10:0] obs; logic [3:0] imm_d, dbg; logic [7:0] imm_e;
    do_reset();
    run_instr(8'h83, 4'h0, 1'b0, obs, imm_d, imm_e, dbg);
    run_instr(8'hB0, 4'h1, 1'b0, obs, imm_d, imm_e, dbg);
    u_if.instr_data = 8'h57;
    smp(); step(); smp(); step();
    reset = 1'b1; u_if.stall = 1'b1;
    step();
    n_tests++; if ({pulses(), u_if.illegal_op} !== {P_NONE, 1'b0}) begin n_fail++; $display("FAIL rst_exec_jump: got %h exp %h", {pulses(), u_if.illegal_op}, {P_NONE, 1'b0}); end
    reset = 1'b0; u_if.stall = 1'b0;
    run_instr(8'h00, 4'h2, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if (obs !== P_WE) begin n_fail++; $display("FAIL rst_exec_refetch: got %h exp %h", obs, P_WE); end
    run_instr(8'h90, 4'h3, 1'b0, obs, imm_d, imm_e, dbg);
    n_tests++; if ({obs, u_if.stack_fault} !== {P_NONE, 1'b1}) begin n_fail++; $display("FAIL rst_exec_depth: got %h exp %h", {obs, u_if.stack_fault}, {P_NONE, 1'b1}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nop_stream();
    test_alu_mem();
    test_branch();
    test_illegal();
    test_stall();
    test_call_depth();
    test_call_ret();
    test_ret_fault();
    test_hlt();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
